instruction_fetch: RTL and testbench

//  IF stage of the 5-stage RV32I pipeline; sits upstream of ID and produces the IF/ID register (pc, ir, valid).

---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_fetch_if.sv | 25 ++
 rtl/instruction_fetch.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and defaults for the RV32I instruction-fetch stage.
package instruction_fetch_pkg;

    typedef enum logic [2:0] {
        IF_ST_IDLE,
        IF_ST_REQ,
        IF_ST_WAIT,
        IF_ST_HOLD,
        IF_ST_HALT
    } if_state_e;

    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory port, hazard/redirect controls and IF/ID register of the fetch stage.
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_ir;
    logic        fetch_misaligned;

    modport master (
        output imem_req_valid, imem_req_addr, ifid_valid, ifid_pc, ifid_ir, fetch_misaligned,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, ifid_valid, ifid_pc, ifid_ir, fetch_misaligned,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: one outstanding word fetch, IF/ID register with stall hold, redirect flush and stale-response drop.
// Optional IF_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky flag and halt fetching.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        drop_q, drop_d;
    logic        mis_q, mis_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_ir_q, ifid_ir_d;

    logic        handshake;
    logic        in_flight;
    logic        load;
    logic [31:0] load_ir;
    logic [31:0] target_pc;
    logic        target_misaligned;

`ifdef IF_MISALIGN_CHECK_EN
    assign target_pc         = bus.redirect_pc;
    assign target_misaligned = |bus.redirect_pc[1:0];
`else
    assign target_pc         = bus.redirect_pc & ~32'd3;
    assign target_misaligned = 1'b0;
`endif

    assign handshake = (state_q == IF_ST_REQ) && bus.imem_req_ready;

    // A request is still owed a response unless it is returning this very cycle.
    assign in_flight = handshake
                    || ((state_q == IF_ST_WAIT) && !bus.imem_rsp_valid)
                    || ((state_q == IF_ST_HALT) && drop_q && !bus.imem_rsp_valid);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        drop_d       = drop_q;
        mis_d        = mis_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_ir_d    = ifid_ir_q;
        load         = 1'b0;
        load_ir      = bus.imem_rsp_data;

        case (state_q)
            IF_ST_IDLE: state_d = IF_ST_REQ;
            IF_ST_REQ: begin
                if (bus.imem_req_ready) state_d = IF_ST_WAIT;
            end
            IF_ST_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = IF_ST_REQ;
                    end else if (!bus.stall) begin
                        load    = 1'b1;
                        state_d = IF_ST_REQ;
                    end else begin
                        buf_d   = bus.imem_rsp_data;
                        state_d = IF_ST_HOLD;
                    end
                end
            end
            IF_ST_HOLD: begin
                if (!bus.stall) begin
                    load    = 1'b1;
                    load_ir = buf_q;
                    state_d = IF_ST_REQ;
                end
            end
            IF_ST_HALT: begin
                if (bus.imem_rsp_valid) drop_d = 1'b0;
            end
            default: state_d = IF_ST_IDLE;
        endcase

        if (load) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_ir_d    = load_ir;
            pc_d         = pc_next(pc_q);
        end else if (!bus.stall) begin
            ifid_valid_d = 1'b0;
            ifid_ir_d    = NOP_INSTR;
        end

        // Redirect overrides stall, any same-cycle load and the HOLD buffer.
        if (bus.redirect) begin
            ifid_valid_d = 1'b0;
            ifid_pc_d    = ifid_pc_q;
            ifid_ir_d    = NOP_INSTR;
            pc_d         = target_pc;
            drop_d       = in_flight;
            if (target_misaligned) begin
                mis_d   = 1'b1;
                state_d = IF_ST_HALT;
            end else begin
                mis_d   = 1'b0;
                state_d = in_flight ? IF_ST_WAIT : IF_ST_REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IF_ST_IDLE;
            pc_q         <= RESET_PC;
            buf_q        <= 32'd0;
            drop_q       <= 1'b0;
            mis_q        <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'd0;
            ifid_ir_q    <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            drop_q       <= drop_d;
            mis_q        <= mis_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_ir_q    <= ifid_ir_d;
        end
    end

    assign bus.imem_req_valid   = (state_q == IF_ST_REQ);
    assign bus.imem_req_addr    = pc_q;
    assign bus.ifid_valid       = ifid_valid_q;
    assign bus.ifid_pc          = ifid_pc_q;
    assign bus.ifid_ir          = ifid_ir_q;
    assign bus.fetch_misaligned = mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory responder, stream-level reference model, literal timeline checks.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_if bus();

    instruction_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory: answers each accepted request 'lat' cycles later with mem_word(addr).
    int          lat = 1;
    int          cnt = 0;
    logic [31:0] pend = 32'd0;
    logic        r_hs;
    logic [31:0] r_addr;

    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            r_hs   = bus.imem_req_valid && bus.imem_req_ready;
            r_addr = bus.imem_req_addr;
            @(posedge clk);
            #1;
            bus.imem_rsp_valid = 1'b0;
            if (r_hs) begin
                cnt  = lat;
                pend = mem_word(r_addr);
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = pend;
                end
            end
        end
    end

    // Reference model: the instruction stream is consecutive words from the last redirect target.
    logic        p_reset = 1'b1, p_stall = 1'b0, p_redir = 1'b0;
    logic [31:0] p_rpc = 32'd0, p_pc = 32'd0, p_ir = NOP;
    logic        p_v = 1'b0;
    logic [31:0] exp_pc = RST_PC;
    logic        halted = 1'b0, exp_mis = 1'b0;
    int          n_loads = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_pc = RST_PC; halted = 1'b0; exp_mis = 1'b0;
                chk("rst_valid", 32'(bus.ifid_valid), 32'd0);
                chk("rst_pc", bus.ifid_pc, 32'd0);
                chk("rst_ir", bus.ifid_ir, NOP);
                chk("rst_req", 32'(bus.imem_req_valid), 32'd0);
            end else if (p_reset) begin
                chk("idle_valid", 32'(bus.ifid_valid), 32'd0);
                chk("idle_ir", bus.ifid_ir, NOP);
                chk("idle_req", 32'(bus.imem_req_valid), 32'd0);
            end else begin
                if (p_redir) begin
                    chk("flush_valid", 32'(bus.ifid_valid), 32'd0);
                    chk("flush_ir", bus.ifid_ir, NOP);
`ifdef IF_MISALIGN_CHECK_EN
                    if (p_rpc[1:0] != 2'b00) begin
                        halted = 1'b1; exp_mis = 1'b1;
                    end else begin
                        halted = 1'b0; exp_mis = 1'b0; exp_pc = p_rpc;
                    end
`else
                    exp_pc = p_rpc & ~32'd3;
`endif
                end else if (p_stall) begin
                    chk("hold_valid", 32'(bus.ifid_valid), 32'(p_v));
                    chk("hold_pc", bus.ifid_pc, p_pc);
                    chk("hold_ir", bus.ifid_ir, p_ir);
                end else if (bus.ifid_valid) begin
                    chk("stream_pc", bus.ifid_pc, exp_pc);
                    chk("stream_ir", bus.ifid_ir, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    n_loads++;
                end else begin
                    chk("bubble_ir", bus.ifid_ir, NOP);
                end
                if (halted)
                    chk("halt_req", 32'(bus.imem_req_valid), 32'd0);
                else if (bus.imem_req_valid)
                    chk("req_addr", bus.imem_req_addr, exp_pc);
            end
            chk("misaligned", 32'(bus.fetch_misaligned), 32'(exp_mis));
            p_reset = reset;     p_stall = bus.stall;
            p_redir = bus.redirect; p_rpc = bus.redirect_pc;
            p_v = bus.ifid_valid; p_pc = bus.ifid_pc; p_ir = bus.ifid_ir;
        end
    end

    // Directed timeline; Ek denotes the k-th rising edge after reset release.
    initial begin
        reset = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'd0;
        tick(2);
        chk("t_rst_ir", bus.ifid_ir, 32'h0000_0013);
        reset = 1'b0;
        tick(1);                                            // E1
        chk("t_first_req", 32'(bus.imem_req_valid), 32'd1);
        chk("t_first_addr", bus.imem_req_addr, 32'h0);
        tick(2);                                            // E3
        chk("t_e3_pc", bus.ifid_pc, 32'h0);
        chk("t_e3_ir", bus.ifid_ir, 32'h1357_9BDF);
        tick(1);                                            // E4
        chk("t_e4_valid", 32'(bus.ifid_valid), 32'd0);
        tick(1);                                            // E5
        chk("t_e5_pc", bus.ifid_pc, 32'h4);
        bus.stall = 1'b1;
        tick(5);                                            // E10: HOLD
        chk("t_stall_valid", 32'(bus.ifid_valid), 32'd1);
        chk("t_stall_pc", bus.ifid_pc, 32'h4);
        chk("t_stall_noreq", 32'(bus.imem_req_valid), 32'd0);
        bus.stall = 1'b0;
        tick(1);                                            // E11
        chk("t_rel_pc", bus.ifid_pc, 32'h8);
        chk("t_rel_ir", bus.ifid_ir, mem_word(32'h8));
        chk("t_rel_addr", bus.imem_req_addr, 32'hC);
        lat = 3;
        tick(1);                                            // E12: WAIT on 0xC
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
        tick(1);                                            // E13
        bus.redirect = 1'b0;
        chk("t_redir_valid", 32'(bus.ifid_valid), 32'd0);
        chk("t_redir_ir", bus.ifid_ir, NOP);
        tick(2);                                            // E15: stale reply dropped
        chk("t_redir_req", 32'(bus.imem_req_valid), 32'd1);
        chk("t_redir_addr", bus.imem_req_addr, 32'h100);
        lat = 1;
        tick(2);                                            // E17
        chk("t_100_pc", bus.ifid_pc, 32'h100);
        bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        tick(1);                                            // E18
        bus.stall = 1'b0; bus.redirect = 1'b0;
        chk("t_flushwins", 32'(bus.ifid_valid), 32'd0);
        tick(1);                                            // E19
        chk("t_200_addr", bus.imem_req_addr, 32'h200);
        tick(2);                                            // E21
        chk("t_200_pc", bus.ifid_pc, 32'h200);
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        tick(1);                                            // E22
        bus.redirect = 1'b0;
        tick(3);                                            // E25
        chk("t_top_pc", bus.ifid_pc, 32'hFFFF_FFFC);
        chk("t_wrap_addr", bus.imem_req_addr, 32'h0);
        lat = 4;
        tick(1);                                            // E26: WAIT
        reset = 1'b1; bus.imem_req_ready = 1'b0;
        #1;
        chk("t_arst_valid", 32'(bus.ifid_valid), 32'd0);
        chk("t_arst_req", 32'(bus.imem_req_valid), 32'd0);
        chk("t_arst_pc", bus.ifid_pc, 32'h0);
        tick(1);                                            // E27
        reset = 1'b0;
        tick(3);                                            // E30: stray reply seen in REQ
        chk("t_stray_addr", bus.imem_req_addr, 32'h0);
        chk("t_stray_valid", 32'(bus.ifid_valid), 32'd0);
        bus.imem_req_ready = 1'b1; lat = 1;
        tick(2);                                            // E32
        chk("t_restart_ir", bus.ifid_ir, 32'h1357_9BDF);
`ifdef IF_MISALIGN_CHECK_EN
        bus.redirect = 1'b1; bus.redirect_pc = 32'h102;
        tick(1);
        bus.redirect = 1'b0;
        chk("t_mis_flag", 32'(bus.fetch_misaligned), 32'd1);
        tick(3);
        chk("t_mis_noreq", 32'(bus.imem_req_valid), 32'd0);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        tick(1);
        bus.redirect = 1'b0;
        chk("t_mis_clear", 32'(bus.fetch_misaligned), 32'd0);
        chk("t_mis_addr", bus.imem_req_addr, 32'h200);
        tick(2);
        chk("t_mis_pc", bus.ifid_pc, 32'h200);
`else
        bus.redirect = 1'b1; bus.redirect_pc = 32'h302;
        tick(1);
        bus.redirect = 1'b0;
        tick(1);
        chk("t_align_addr", bus.imem_req_addr, 32'h300);
        tick(2);
        chk("t_align_pc", bus.ifid_pc, 32'h300);
`endif
        tick(2);
        chk("t_n_loads", 32'(n_loads), 32'd8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
